aes_stream_feeder: RTL and testbench
====================================

Name: aes_stream_feeder

Overview:
- Streaming adapter placed directly around aes_core_serial.
- Upstream side: accepts 32-bit words on a valid/ready stream and assembles them into 128-bit blocks.
- Core side: launches each block on the core with a one-cycle start pulse, detects completion from the core's ready low→high sequence, captures the result, and re-serialises it as 32-bit words on an output valid/ready stream.
- Separate input and output buffers let block N+1 load while block N is processed and while block N−1 drains.

Parameters:
- WAIT_LIMIT, 16, max cycles after core_start for core_ready to fall before the launch is declared failed.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  128  cipher key; the host holds it stable while busy=1.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  32  input word; the first word of a block is bits [127:96] (NIST byte order).
- s_enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with word 0 of each block.
- m_valid  out  1  output word valid.
- m_ready  in  1  output word consumed when m_valid & m_ready.
- m_data  out  32  output word; the first word out is result bits [127:96].
- core_start  out  1  one-cycle launch pulse to aes_core_serial.
- core_enc_dec  out  1  mode for the current launch.
- core_data_in  out  128  block for the current launch.
- core_key_in  out  128  driven directly from key_in.
- core_data_out  in  128  core result; stable while core_ready=1 until the next start.
- core_ready  in  1  core idle/done flag (1 = idle).
- busy  out  1  any buffer occupied or core FSM not IDLE.
- err  out  1  sticky launch-timeout flag; cleared only by reset.
- blocks_done  out  CNT_W  count of blocks fully emitted; wraps at 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0) clears everything: s_ready=0 during reset; all outputs 0, including m_valid, core_start, err, blocks_done, busy. Both buffers empty, word indices 0, FSM IDLE. Asserting rst_n mid-operation discards all blocks in flight. The first clock after release gives s_ready=1.
- Input buffer (ibuf):
  - s_ready = !ibuf_full.
  - Each accepted word goes to slot idx (0..3), with idx 0 at [127:96]; idx wraps 3→0.
  - At idx 0 the block's mode is latched from s_enc_dec.
  - ibuf_full sets on the 4th accept. It clears in the cycle core_ready is seen low in WAIT_LO, i.e. once the core has latched the block.
- Core FSM:
  - IDLE: if ibuf_full and core_ready=1 → LAUNCH.
  - LAUNCH: core_start=1 for exactly one cycle; core_data_in and core_enc_dec are driven from ibuf and held until ibuf clears. Next state WAIT_LO; the timer resets.
  - WAIT_LO: if core_ready=0 → WAIT_HI and release ibuf. Otherwise the timer counts; at WAIT_LIMIT cycles set err, drop the block (clear ibuf) and go to IDLE.
  - WAIT_HI: when core_ready=1 → CAPTURE.
  - CAPTURE: if the output buffer is empty, load it from core_data_out, set obuf_full and go to IDLE. Otherwise stay in CAPTURE; the core result stays stable because no new start is issued.
- Output buffer (obuf):
  - m_valid = obuf_full; m_data = slot oidx.
  - oidx advances on each m_valid & m_ready. After the 4th word, obuf_full clears and blocks_done increments.
  - m_data is held stable while m_valid=1 & m_ready=0.
- Simultaneous events:
  - A capture and the final output word in the same cycle: the final word completes first. The capture proceeds in the next cycle, not the same one.
  - A 4th input accept in the same cycle as the ibuf release: not possible, since ibuf accepts only while not full.
- Latency:
  - 4th input word accepted at edge T → core_start high in cycle T+1 (when the FSM is IDLE and core_ready=1).
  - core_ready rising seen at edge R → obuf loaded at R+1 → first m_valid at R+1, provided obuf is empty.
- busy = ibuf_full | obuf_full | (idx≠0) | (FSM≠IDLE).

Test Plan:
- Encrypt, key 000102030405060708090a0b0c0d0e0f, words 00112233,44556677,8899aabb,ccddeeff, enc=1 → m_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; exactly one core_start pulse; blocks_done=1.
- Decrypt, key 2b7e151628aed2a6abf7158809cf4f3c, words 3925841d,02dc09fb,dc118597,196a0b32, enc=0 → 3243f6a8,885a308d,313198a2,e0370734.
- Back-to-back: zero key, block 0 enc then block 1 = 66e94bd4ef8a2c3b884cfa59ca342b2e dec, with s_valid held high.
  - Block 1 loads while block 0 runs; s_ready drops after its 4th word until block 0 is latched.
  - Outputs in order: 66e94bd4,ef8a2c3b,884cfa59,ca342b2e then 00000000 ×4; blocks_done=2.
- Backpressure: m_ready=0 for 100 cycles after the first result while a 2nd block completes.
  - FSM holds CAPTURE; m_data stays 69c4e0d8.
  - After release, both blocks emit intact with no loss or duplication.
- Reset mid-operation: assert rst_n=0 during WAIT_HI.
  - m_valid, core_start, busy and blocks_done go 0 immediately.
  - A following fresh NIST C.1 block produces the correct ciphertext.
- Timeout: stub core with core_ready tied 1.
  - After a launch, err=1 exactly WAIT_LIMIT cycles after core_start; the block is dropped; m_valid never asserts.
  - s_ready returns to 1.

Source files
------------

// File: rtl/aes_stream_feeder.sv
// Streaming wrapper for aes_core_serial: packs 32-bit words into 128-bit blocks,
// launches them on the core and re-serialises each result onto an output stream.
module aes_stream_feeder #(
    parameter int WAIT_LIMIT = 16,   // must be >= 2
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key_in,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_enc_dec,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             core_start,
    output logic             core_enc_dec,
    output logic [127:0]     core_data_in,
    output logic [127:0]     core_key_in,
    input  logic [127:0]     core_data_out,
    input  logic             core_ready,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] blocks_done
);

    // state   | meaning
    // IDLE    | waiting for a full ibuf and an idle core
    // LAUNCH  | core_start pulse, block presented from ibuf
    // WAIT_LO | waiting for core_ready to fall (core latched block), timed
    // WAIT_HI | core running, waiting for core_ready to rise
    // CAPTURE | result ready, waiting for obuf to be empty
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    localparam int TW = $clog2(WAIT_LIMIT + 1);

    state_t             state;
    state_t             state_nxt;
    logic               run;
    logic               ibuf_full;
    logic [1:0]         idx;
    logic [127:0]       ibuf_data;
    logic               ibuf_mode;
    logic               obuf_full;
    logic [1:0]         oidx;
    logic [127:0]       obuf_data;
    logic [TW-1:0]      timer;
    logic [CNT_W-1:0]   done_cnt;
    logic               err_q;
    logic               accept;
    logic               take;
    logic               ib_release;
    logic               ib_drop;
    logic               ob_load;

    // run keeps s_ready low while in reset and rises on the first clock after release
    assign s_ready      = run & ~ibuf_full;
    assign accept       = s_valid & s_ready;
    assign m_valid      = obuf_full;
    assign take         = obuf_full & m_ready;
    assign core_data_in = ibuf_data;
    assign core_enc_dec = ibuf_mode;
    assign core_key_in  = key_in;
    assign err          = err_q;
    assign blocks_done  = done_cnt;
    assign busy         = ibuf_full | obuf_full | (idx != 2'd0) | (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ibuf_full && core_ready) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!core_ready)         state_nxt = WAIT_HI;
                else if (timer == '0)    state_nxt = IDLE;
            end
            WAIT_HI: if (core_ready) state_nxt = CAPTURE;
            CAPTURE: if (!obuf_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start = 1'b0;
        ib_release = 1'b0;
        ib_drop    = 1'b0;
        ob_load    = 1'b0;
        case (state)
            LAUNCH:  core_start = 1'b1;
            WAIT_LO: begin
                if (!core_ready)      ib_release = 1'b1;
                else if (timer == '0) ib_drop    = 1'b1;
            end
            CAPTURE: ob_load = ~obuf_full;
            default: ;
        endcase
    end

    // Loaded so that err appears exactly WAIT_LIMIT cycles after the start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                timer <= TW'(WAIT_LIMIT - 2);
            end else if (state == WAIT_LO && timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (ib_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            ibuf_full <= 1'b0;
            idx       <= 2'd0;
            ibuf_data <= '0;
            ibuf_mode <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                case (idx)
                    2'd0:    ibuf_data[127:96] <= s_data;
                    2'd1:    ibuf_data[95:64]  <= s_data;
                    2'd2:    ibuf_data[63:32]  <= s_data;
                    default: ibuf_data[31:0]   <= s_data;
                endcase
                if (idx == 2'd0) begin
                    ibuf_mode <= s_enc_dec;
                end
                if (idx == 2'd3) begin
                    ibuf_full <= 1'b1;
                end
                idx <= idx + 2'd1;
            end else if (ib_release || ib_drop) begin
                ibuf_full <= 1'b0;
            end
        end
    end

    // take and ob_load are exclusive: a capture waits until the last word has left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_full <= 1'b0;
            oidx      <= 2'd0;
            obuf_data <= '0;
            done_cnt  <= '0;
        end else if (take) begin
            oidx <= oidx + 2'd1;
            if (oidx == 2'd3) begin
                obuf_full <= 1'b0;
                done_cnt  <= done_cnt + 1'b1;
            end
        end else if (ob_load) begin
            obuf_data <= core_data_out;
            obuf_full <= 1'b1;
        end
    end

    always_comb begin
        case (oidx)
            2'd0:    m_data = obuf_data[127:96];
            2'd1:    m_data = obuf_data[95:64];
            2'd2:    m_data = obuf_data[63:32];
            default: m_data = obuf_data[31:0];
        endcase
    end

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Bench for aes_stream_feeder with a behavioural serial-core stub answering known
// AES vectors; outputs are checked by a scoreboard monitor.
module tb_aes_stream_feeder;

    localparam int WL  = 16;
    localparam int CW  = 16;
    localparam int LAT = 12;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ZCT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [31:0] s_data = '0;
    logic s_enc_dec = 1'b0;
    logic m_valid;
    logic m_ready = 1'b1;
    logic [31:0] m_data;
    logic core_start;
    logic core_enc_dec;
    logic [127:0] core_data_in;
    logic [127:0] core_key_in;
    logic [127:0] core_data_out;
    logic core_ready;
    logic busy;
    logic err;
    logic [CW-1:0] blocks_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    logic [31:0] exp_q[$];

    aes_stream_feeder #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_enc_dec(s_enc_dec),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_start(core_start), .core_enc_dec(core_enc_dec), .core_data_in(core_data_in),
        .core_key_in(core_key_in), .core_data_out(core_data_out), .core_ready(core_ready),
        .busy(busy), .err(err), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d,
                                             input logic e);
        if (k == K1 && e && d == PT1)        return CT1;
        if (k == K1 && !e && d == CT1)       return PT1;
        if (k == K2 && !e && d == CT2)       return PT2;
        if (k == K2 && e && d == PT2)        return CT2;
        if (k == '0 && e && d == '0)         return ZCT;
        if (k == '0 && !e && d == ZCT)       return '0;
        return {4{32'hdeadbeef}};
    endfunction

    // Core stub: ready drops the cycle after start, result appears LAT cycles later
    logic stuck = 1'b0;
    logic cr_m;
    int cnt;
    logic [127:0] dout_m, lat_d, lat_k;
    logic lat_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_m   <= 1'b1;
            cnt    <= 0;
            dout_m <= '0;
        end else if (cr_m && core_start && !stuck) begin
            cr_m  <= 1'b0;
            cnt   <= LAT;
            lat_d <= core_data_in;
            lat_k <= core_key_in;
            lat_e <= core_enc_dec;
        end else if (!cr_m) begin
            if (cnt == 1) begin
                cr_m   <= 1'b1;
                dout_m <= aes_ref(lat_k, lat_d, lat_e);
            end
            cnt <= cnt - 1;
        end
    end
    assign core_ready    = stuck ? 1'b1 : cr_m;
    assign core_data_out = dout_m;

    always @(negedge clk) begin
        if (core_start) starts++;
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", m_data);
            end else begin
                check("m_data", {96'd0, m_data}, {96'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic send_word(input logic [31:0] w, input logic enc);
        int t = 0;
        s_valid = 1'b1;
        s_data = w;
        s_enc_dec = enc;
        @(negedge clk);
        while (!s_ready && t < 500) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL s_ready_wait: got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [127:0] b, input logic enc, input logic [127:0] res,
                              input bit push);
        if (push) begin
            exp_q.push_back(res[127:96]);
            exp_q.push_back(res[95:64]);
            exp_q.push_back(res[63:32]);
            exp_q.push_back(res[31:0]);
        end
        send_word(b[127:96], enc);
        send_word(b[95:64], enc);
        send_word(b[63:32], enc);
        send_word(b[31:0], enc);
    endtask

    task automatic wait_blocks(input int n);
        int t = 0;
        @(negedge clk);
        while (int'(blocks_done) != n && t < 2000) begin
            t++;
            @(negedge clk);
        end
        check("blocks_done", blocks_done, n);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        s_valid = 1'b0;
        stuck = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int c0;
        int t;
        bit bad;

        key_in = K1;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_blocks_done", blocks_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_release", s_ready, 1);

        // Encrypt NIST C.1
        s0 = starts;
        send_block(PT1, 1'b1, CT1, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("start_not_yet", core_start, 0);
        check("busy_loaded", busy, 1);
        @(negedge clk);
        check("start_latency", core_start, 1);
        wait_blocks(1);
        check("enc_one_start", starts - s0, 1);

        // Decrypt FIPS-197 example
        do_reset();
        key_in = K2;
        send_block(CT2, 1'b0, PT2, 1'b1);
        s_valid = 1'b0;
        wait_blocks(1);

        // Back-to-back, s_valid held high
        do_reset();
        key_in = '0;
        s0 = starts;
        send_block('0, 1'b1, ZCT, 1'b1);
        send_block(ZCT, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("b2b_s_ready_low", s_ready, 0);
        s_valid = 1'b0;
        wait_blocks(2);
        check("b2b_starts", starts - s0, 2);

        // Backpressure
        do_reset();
        key_in = K1;
        m_ready = 1'b0;
        s0 = starts;
        send_block(PT1, 1'b1, CT1, 1'b1);
        s_valid = 1'b0;
        t = 0;
        while (!m_valid && t < 500) begin
            t++;
            @(negedge clk);
        end
        check("bp_first_valid", m_valid, 1);
        @(posedge clk);
        #1;
        send_block(PT1, 1'b1, CT1, 1'b1);
        s_valid = 1'b0;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (!m_valid || m_data !== 32'h69c4e0d8) bad = 1'b1;
        end
        check("bp_hold_stable", bad, 0);
        check("bp_starts", starts - s0, 2);
        check("bp_ibuf_free", s_ready, 1);
        check("bp_none_done", blocks_done, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_blocks(2);

        // Reset while the core is running
        do_reset();
        key_in = K1;
        send_block(PT1, 1'b1, CT1, 1'b1);
        s_valid = 1'b0;
        t = 0;
        while (core_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("mid_busy_before", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_m_valid", m_valid, 0);
        check("mid_core_start", core_start, 0);
        check("mid_busy", busy, 0);
        check("mid_blocks_done", blocks_done, 0);
        check("mid_s_ready", s_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_block(PT1, 1'b1, CT1, 1'b1);
        s_valid = 1'b0;
        wait_blocks(1);

        // Launch timeout with a core that never drops ready
        do_reset();
        stuck = 1'b1;
        s0 = starts;
        send_block(PT1, 1'b1, CT1, 1'b0);
        s_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!core_start && t < 50) begin
            t++;
            @(negedge clk);
        end
        c0 = cyc;
        t = 0;
        bad = 1'b0;
        while (!err && t < 100) begin
            t++;
            @(negedge clk);
            if (m_valid) bad = 1'b1;
        end
        check("timeout_cycles", cyc - c0, WL);
        repeat (20) begin
            @(negedge clk);
            if (m_valid) bad = 1'b1;
        end
        check("timeout_no_output", bad, 0);
        check("timeout_err_sticky", err, 1);
        check("timeout_s_ready", s_ready, 1);
        check("timeout_busy", busy, 0);
        check("timeout_one_start", starts - s0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
